// File: rtl/control_pipe.sv
// control_pipe
//   Carries the decoder's 12-bit control bundle from ID through the EX, MEM
//   and WB stages. Each field is presented at the stage that consumes it.
//   The block also resolves the destination register in ID, detects
//   load-use hazards (stall plus an EX bubble) and produces the EX-stage
//   forwarding selects.
//
//   Bundle layout (MSB first):
//     {RegDst[1:0], Jump, Branch, MemRead, MemtoReg[1:0], ALUOp[1:0],
//      MemWrite, ALUSrc, RegWrite}
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   id_valid, id_ctrl           ID instruction valid flag and control bundle
//   id_rs, id_rt, id_rd         ID register fields
//   flush                       kill the ID instruction
//   stall                       load-use hazard; upstream holds PC and IF/ID
//   ex_alu_op, ex_alu_src,
//   ex_branch, ex_jump          EX-stage controls
//   fwd_a, fwd_b                operand selects: 00 regfile, 10 MEM, 01 WB
//   mem_read, mem_write         data-memory strobes in MEM
//   wb_mem_to_reg, wb_reg_write,
//   wb_wreg                     write-back controls and write address
module control_pipe (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [11:0] id_ctrl,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic        flush,
    output logic        stall,
    output logic [1:0]  ex_alu_op,
    output logic        ex_alu_src,
    output logic        ex_branch,
    output logic        ex_jump,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic        mem_read,
    output logic        mem_write,
    output logic [1:0]  wb_mem_to_reg,
    output logic        wb_reg_write,
    output logic [4:0]  wb_wreg
);

    // RegDst is consumed in ID, so EX only keeps the lower ten bundle bits.
    localparam int J_BIT  = 9;
    localparam int BR_BIT = 8;
    localparam int MR_BIT = 7;
    localparam int MW_BIT = 2;
    localparam int AS_BIT = 1;
    localparam int RW_BIT = 0;

    logic [4:0] id_wreg;

    logic       ex_valid;
    logic [9:0] ex_ctrl;
    logic [4:0] ex_rs;
    logic [4:0] ex_rt;
    logic [4:0] ex_wreg;

    logic       mem_valid;
    logic       mem_rd_q;
    logic       mem_wr_q;
    logic [1:0] mem_m2r_q;
    logic       mem_rw_q;
    logic [4:0] mem_wreg;

    logic       wb_valid;
    logic [1:0] wb_m2r_q;
    logic       wb_rw_q;
    logic [4:0] wb_wreg_q;

    logic       mem_hit_a;
    logic       mem_hit_b;
    logic       wb_hit_a;
    logic       wb_hit_b;

    always_comb begin
        id_wreg = 5'd0;
        case (id_ctrl[11:10])
            2'b00:   id_wreg = id_rt;
            2'b01:   id_wreg = id_rd;
            2'b10:   id_wreg = 5'd31;
            default: id_wreg = 5'd0;
        endcase
    end

    // The load in EX is the only producer that cannot be forwarded in time.
    assign stall = id_valid & ex_valid & ex_ctrl[MR_BIT] & (ex_wreg != 5'd0) &
                   ((ex_wreg == id_rs) | (ex_wreg == id_rt));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid  <= 1'b0;
            ex_ctrl   <= '0;
            ex_rs     <= '0;
            ex_rt     <= '0;
            ex_wreg   <= '0;
            mem_valid <= 1'b0;
            mem_rd_q  <= 1'b0;
            mem_wr_q  <= 1'b0;
            mem_m2r_q <= '0;
            mem_rw_q  <= 1'b0;
            mem_wreg  <= '0;
            wb_valid  <= 1'b0;
            wb_m2r_q  <= '0;
            wb_rw_q   <= 1'b0;
            wb_wreg_q <= '0;
        end else begin
            if (stall || flush) begin
                ex_valid <= 1'b0;
                ex_ctrl  <= '0;
                ex_rs    <= '0;
                ex_rt    <= '0;
                ex_wreg  <= '0;
            end else begin
                ex_valid <= id_valid;
                ex_ctrl  <= id_ctrl[9:0];
                ex_rs    <= id_rs;
                ex_rt    <= id_rt;
                ex_wreg  <= id_wreg;
            end
            // MEM and WB keep draining during a stall.
            mem_valid <= ex_valid;
            mem_rd_q  <= ex_ctrl[MR_BIT];
            mem_wr_q  <= ex_ctrl[MW_BIT];
            mem_m2r_q <= ex_ctrl[6:5];
            mem_rw_q  <= ex_ctrl[RW_BIT];
            mem_wreg  <= ex_wreg;
            wb_valid  <= mem_valid;
            wb_m2r_q  <= mem_m2r_q;
            wb_rw_q   <= mem_rw_q;
            wb_wreg_q <= mem_wreg;
        end
    end

    assign mem_hit_a = mem_valid & mem_rw_q & (mem_wreg != 5'd0) & (mem_wreg == ex_rs);
    assign mem_hit_b = mem_valid & mem_rw_q & (mem_wreg != 5'd0) & (mem_wreg == ex_rt);
    assign wb_hit_a  = wb_valid & wb_rw_q & (wb_wreg_q != 5'd0) & (wb_wreg_q == ex_rs);
    assign wb_hit_b  = wb_valid & wb_rw_q & (wb_wreg_q != 5'd0) & (wb_wreg_q == ex_rt);

    // The younger MEM result takes priority over WB.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (ex_valid) begin
            if (mem_hit_a)     fwd_a = 2'b10;
            else if (wb_hit_a) fwd_a = 2'b01;
            if (mem_hit_b)     fwd_b = 2'b10;
            else if (wb_hit_b) fwd_b = 2'b01;
        end
    end

    assign ex_alu_op     = ex_valid ? ex_ctrl[4:3] : 2'b00;
    assign ex_alu_src    = ex_valid & ex_ctrl[AS_BIT];
    assign ex_branch     = ex_valid & ex_ctrl[BR_BIT];
    assign ex_jump       = ex_valid & ex_ctrl[J_BIT];
    assign mem_read      = mem_valid & mem_rd_q;
    assign mem_write     = mem_valid & mem_wr_q;
    assign wb_mem_to_reg = wb_valid ? wb_m2r_q : 2'b00;
    assign wb_reg_write  = wb_valid & wb_rw_q;
    assign wb_wreg       = wb_valid ? wb_wreg_q : 5'd0;

endmodule

// File: tb/tb_control_pipe.sv
module tb_control_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [11:0] id_ctrl;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        flush;
    logic        stall;
    logic [1:0]  ex_alu_op;
    logic        ex_alu_src, ex_branch, ex_jump;
    logic [1:0]  fwd_a, fwd_b;
    logic        mem_read, mem_write;
    logic [1:0]  wb_mem_to_reg;
    logic        wb_reg_write;
    logic [4:0]  wb_wreg;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    control_pipe dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush),
        .stall(stall), .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src),
        .ex_branch(ex_branch), .ex_jump(ex_jump), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .mem_read(mem_read), .mem_write(mem_write), .wb_mem_to_reg(wb_mem_to_reg),
        .wb_reg_write(wb_reg_write), .wb_wreg(wb_wreg)
    );

    logic [19:0] dut_vec;
    assign dut_vec = {stall, ex_alu_op, ex_alu_src, ex_branch, ex_jump, fwd_a, fwd_b,
                      mem_read, mem_write, wb_mem_to_reg, wb_reg_write, wb_wreg};

    localparam logic [11:0] RTYPE = 12'h411;
    localparam logic [11:0] LW    = 12'h0A3;
    localparam logic [11:0] ADDI  = 12'h003;
    localparam logic [11:0] SW    = 12'h006;
    localparam logic [11:0] JAL   = 12'hA01;

    // Reference model: one instruction record per stage, shifted as a whole.
    typedef struct packed {
        logic        v;
        logic [11:0] c;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  wr;
    } ent_t;

    ent_t m_ex = '0, m_mem = '0, m_wb = '0;

    function automatic logic [4:0] dest(input logic [11:0] c, input logic [4:0] rt, input logic [4:0] rd);
        case (c[11:10])
            2'b00:   return rt;
            2'b01:   return rd;
            2'b10:   return 5'd31;
            default: return 5'd0;
        endcase
    endfunction

    function automatic logic writes(input ent_t e, input logic [4:0] r);
        return e.v && e.c[0] && (e.wr != 5'd0) && (e.wr == r);
    endfunction

    function automatic logic model_stall();
        return id_valid && m_ex.v && m_ex.c[7] && (m_ex.wr != 5'd0) &&
               ((m_ex.wr == id_rs) || (m_ex.wr == id_rt));
    endfunction

    function automatic logic [1:0] model_fwd(input logic [4:0] r);
        if (!m_ex.v)          return 2'b00;
        if (writes(m_mem, r)) return 2'b10;
        if (writes(m_wb, r))  return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [19:0] model_vec();
        return {model_stall(),
                m_ex.v ? m_ex.c[4:3] : 2'b00, m_ex.v & m_ex.c[1], m_ex.v & m_ex.c[8], m_ex.v & m_ex.c[9],
                model_fwd(m_ex.rs), model_fwd(m_ex.rt),
                m_mem.v & m_mem.c[7], m_mem.v & m_mem.c[2],
                m_wb.v ? m_wb.c[6:5] : 2'b00, m_wb.v & m_wb.c[0], m_wb.v ? m_wb.wr : 5'd0};
    endfunction

    task automatic drive(input logic v, input logic [11:0] c, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd, input logic fl);
        id_valid = v;
        id_ctrl  = c;
        id_rs    = rs;
        id_rt    = rt;
        id_rd    = rd;
        flush    = fl;
        #1;
    endtask

    task automatic tick();
        ent_t nex;
        nex = '0;
        if (id_valid && !flush && !model_stall()) begin
            nex.v  = 1'b1;
            nex.c  = id_ctrl;
            nex.rs = id_rs;
            nex.rt = id_rt;
            nex.wr = dest(id_ctrl, id_rt, id_rd);
        end
        @(posedge clk);
        if (!rst_n) begin
            m_ex = '0; m_mem = '0; m_wb = '0;
        end else begin
            m_wb = m_mem; m_mem = m_ex; m_ex = nex;
        end
        #1;
    endtask

    task automatic drain();
        drive(1'b0, 12'h000, 5'd0, 5'd0, 5'd0, 1'b0);
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, RTYPE, 5'd1, 5'd2, 5'd7, 1'b0);
        tick();
        tick();
        checks++;
        if (dut_vec !== 20'd0) begin
            errors++; $display("FAIL reset_outputs got=%h exp=00000", dut_vec);
        end
        checks++;
        if (dut_vec !== model_vec()) begin
            errors++; $display("FAIL reset_model got=%h exp=%h", dut_vec, model_vec());
        end
        rst_n = 1'b1;
        #1;
        tick();
        drive(1'b0, 12'h000, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();
        tick();
        checks++;
        if (wb_wreg !== 5'd7 || wb_reg_write !== 1'b1) begin
            errors++; $display("FAIL reset_release_wb got wreg=%0d rw=%0b exp wreg=7 rw=1", wb_wreg, wb_reg_write);
        end
    endtask

    task automatic test_lw_latency();
        drain();
        drive(1'b1, LW, 5'd1, 5'd5, 5'd0, 1'b0);
        tick();
        drive(1'b0, 12'h000, 5'd0, 5'd0, 5'd0, 1'b0);
        checks++;
        if (ex_alu_src !== 1'b1 || ex_alu_op !== 2'b00) begin
            errors++; $display("FAIL lw_ex got src=%0b op=%b exp src=1 op=00", ex_alu_src, ex_alu_op);
        end
        tick();
        checks++;
        if (mem_read !== 1'b1 || mem_write !== 1'b0) begin
            errors++; $display("FAIL lw_mem got rd=%0b wr=%0b exp rd=1 wr=0", mem_read, mem_write);
        end
        tick();
        checks++;
        if (wb_mem_to_reg !== 2'b01 || wb_reg_write !== 1'b1 || wb_wreg !== 5'd5) begin
            errors++; $display("FAIL lw_wb got m2r=%b rw=%0b wreg=%0d exp m2r=01 rw=1 wreg=5",
                               wb_mem_to_reg, wb_reg_write, wb_wreg);
        end
    endtask

    task automatic test_load_use();
        int nstall;
        drain();
        drive(1'b1, LW, 5'd1, 5'd8, 5'd0, 1'b0);
        tick();
        drive(1'b1, RTYPE, 5'd8, 5'd9, 5'd10, 1'b0);
        nstall = int'(stall);
        tick();
        nstall += int'(stall);
        checks++;
        if (nstall != 1) begin
            errors++; $display("FAIL load_use_stall_cycles got=%0d exp=1", nstall);
        end
        checks++;
        if ({ex_alu_op, ex_alu_src, ex_branch, ex_jump, fwd_a, fwd_b} !== 9'd0) begin
            errors++; $display("FAIL load_use_bubble got op=%b src=%0b fa=%b fb=%b exp all 0",
                               ex_alu_op, ex_alu_src, fwd_a, fwd_b);
        end
        tick();
        drive(1'b0, 12'h000, 5'd0, 5'd0, 5'd0, 1'b0);
        checks++;
        if (fwd_a !== 2'b01 || fwd_b !== 2'b00 || ex_alu_op !== 2'b10) begin
            errors++; $display("FAIL load_use_fwd got fa=%b fb=%b op=%b exp fa=01 fb=00 op=10", fwd_a, fwd_b, ex_alu_op);
        end
    endtask

    task automatic test_fwd_priority();
        drain();
        drive(1'b1, ADDI, 5'd1, 5'd3, 5'd0, 1'b0); tick();
        drive(1'b1, ADDI, 5'd2, 5'd3, 5'd0, 1'b0); tick();
        drive(1'b1, RTYPE, 5'd3, 5'd3, 5'd4, 1'b0); tick();
        checks++;
        if (fwd_a !== 2'b10 || fwd_b !== 2'b10) begin
            errors++; $display("FAIL fwd_mem_priority got fa=%b fb=%b exp 10 10", fwd_a, fwd_b);
        end
        drain();
        drive(1'b1, ADDI, 5'd1, 5'd3, 5'd0, 1'b0); tick();
        drive(1'b1, ADDI, 5'd2, 5'd3, 5'd0, 1'b0); tick();
        drive(1'b1, RTYPE, 5'd1, 5'd2, 5'd20, 1'b0); tick();
        drive(1'b1, RTYPE, 5'd3, 5'd3, 5'd4, 1'b0); tick();
        checks++;
        if (fwd_a !== 2'b01 || fwd_b !== 2'b01) begin
            errors++; $display("FAIL fwd_wb got fa=%b fb=%b exp 01 01", fwd_a, fwd_b);
        end
    endtask

    task automatic test_zero_jal_sw();
        drain();
        drive(1'b1, RTYPE, 5'd1, 5'd2, 5'd0, 1'b0); tick();
        drive(1'b1, RTYPE, 5'd0, 5'd0, 5'd5, 1'b0); tick();
        checks++;
        if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
            errors++; $display("FAIL zero_no_fwd got fa=%b fb=%b exp 00 00", fwd_a, fwd_b);
        end
        drain();
        drive(1'b1, JAL, 5'd0, 5'd0, 5'd0, 1'b0); tick();
        checks++;
        if (ex_jump !== 1'b1) begin
            errors++; $display("FAIL jal_ex_jump got=%0b exp=1", ex_jump);
        end
        drive(1'b0, 12'h000, 5'd0, 5'd0, 5'd0, 1'b0); tick(); tick();
        checks++;
        if (wb_wreg !== 5'd31 || wb_reg_write !== 1'b1) begin
            errors++; $display("FAIL jal_wreg got wreg=%0d rw=%0b exp wreg=31 rw=1", wb_wreg, wb_reg_write);
        end
        drain();
        drive(1'b1, SW, 5'd1, 5'd12, 5'd0, 1'b0); tick();
        drive(1'b1, RTYPE, 5'd12, 5'd12, 5'd13, 1'b0);
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL sw_no_stall got=%0b exp=0", stall);
        end
        tick();
        checks++;
        if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
            errors++; $display("FAIL sw_no_fwd got fa=%b fb=%b exp 00 00", fwd_a, fwd_b);
        end
    endtask

    task automatic test_flush_stall();
        drain();
        drive(1'b1, LW, 5'd1, 5'd8, 5'd0, 1'b0); tick();
        drive(1'b1, RTYPE, 5'd8, 5'd9, 5'd10, 1'b1);
        checks++;
        if (stall !== 1'b1) begin
            errors++; $display("FAIL flush_stall_reported got=%0b exp=1", stall);
        end
        tick();
        drive(1'b1, RTYPE, 5'd8, 5'd9, 5'd10, 1'b0);
        checks++;
        if (stall !== 1'b0 || ex_alu_op !== 2'b00 || mem_read !== 1'b1) begin
            errors++; $display("FAIL flush_stall_bubble got stall=%0b op=%b mrd=%0b exp 0 00 1", stall, ex_alu_op, mem_read);
        end
        tick();
        drive(1'b0, 12'h000, 5'd0, 5'd0, 5'd0, 1'b0);
        checks++;
        if (ex_alu_op !== 2'b10 || fwd_a !== 2'b01) begin
            errors++; $display("FAIL flush_stall_resume got op=%b fa=%b exp op=10 fa=01", ex_alu_op, fwd_a);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            rst_n = ($urandom_range(0, 39) != 0);
            drive(1'($urandom_range(0, 3) != 0), 12'($urandom),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 7) == 0));
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++; $display("FAIL random_cycle_%0d got=%h exp=%h", i, dut_vec, model_vec());
            end
            tick();
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 12'h000, 5'd0, 5'd0, 5'd0, 1'b0);
        test_reset();
        test_lw_latency();
        test_load_use();
        test_fwd_priority();
        test_zero_jal_sw();
        test_flush_stall();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_pipe.md
# control_pipe

Pipelines the 12-bit control bundle produced by the opcode decoder from ID through the EX, MEM and WB stages, so each field is delivered at the stage that uses it. It also resolves the destination register and detects load-use hazards, which it handles by stalling and inserting a bubble. It generates the EX-stage forwarding selects. It sits between the decoder/register-file read in ID and the ALU, data-memory and write-back muxes of the pipelined datapath.

## Interface
- No parameters; all widths are fixed by the MIPS ISA (5-bit register numbers, 12-bit bundle).
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_ctrl  in  12  decoder bundle, MSB first: {RegDst[1:0], Jump, Branch, MemRead, MemtoReg[1:0], ALUOp[1:0], MemWrite, ALUSrc, RegWrite}
- id_rs, id_rt, id_rd  in  5 each  register fields of the ID instruction
- flush  in  1  kill the ID instruction (taken branch/jump resolved downstream)
- stall  out  1  load-use hazard; upstream holds PC and IF/ID
- ex_alu_op  out  2  ALUOp in EX
- ex_alu_src  out  1  ALUSrc in EX
- ex_branch  out  1  Branch in EX
- ex_jump  out  1  Jump in EX
- fwd_a, fwd_b  out  2 each  ALU operand select for rs/rt: 00 register file, 10 MEM result, 01 WB result
- mem_read, mem_write  out  1 each  data-memory strobes in MEM
- wb_mem_to_reg  out  2  MemtoReg in WB
- wb_reg_write  out  1  register-file write enable
- wb_wreg  out  5  register-file write address

## Operation
- Write register resolution in ID:
  - RegDst 00 selects id_rt; 01 selects id_rd; 10 selects 31; 11 selects 0.
  - The resolved value is stored with the EX entry as ex_wreg.
- Stage registers:
  - EX holds {valid, full ctrl, rs, rt, wreg}.
  - MEM holds {valid, MemRead, MemWrite, MemtoReg, RegWrite, wreg}.
  - WB holds {valid, MemtoReg, RegWrite, wreg}.
  - Every output is gated by its stage valid, so a bubble drives 0.
- Load-use hazard:
  - stall = id_valid & ex_valid & ex MemRead & ex_wreg≠0 & (ex_wreg==id_rs | ex_wreg==id_rt).
  - stall is combinational.
- EX capture each cycle:
  - If stall or flush is asserted, a bubble (valid=0, ctrl=0) is loaded.
  - Otherwise {id_valid, id_ctrl, …} is loaded.
  - MEM and WB always advance; a stall never freezes them.
- Forwarding for operand A, compared against ex_rs:
  - 10 if MEM valid & RegWrite & mem_wreg≠0 & mem_wreg==ex_rs.
  - Otherwise 01 if the same condition holds for WB.
  - Otherwise 00.
  - MEM has priority over WB. Register 0 is never forwarded.
  - fwd_b uses the same rule against ex_rt.
- A bubble in any stage matches nothing.
- flush has no effect on instructions already in EX, MEM or WB.

## Timing
- Reset: with rst_n low at a rising edge, all stage registers clear.
  - All outputs are 0 from that edge, including stall (EX is invalid).
  - Reset overrides stall and flush. Instructions in flight are discarded.
- Latency: a bundle accepted at edge N drives ex_* after N, mem_* after N+1 and wb_* after N+2.
- stall lasts exactly one cycle per load-use pair, because the load leaves EX on the next edge.
- stall and flush asserted together: a single bubble is inserted and stall is still reported.
- Back-to-back writes to the same register: the MEM entry wins the forward.
- jal (RegDst=10, RegWrite=1) produces wb_wreg=31.
- sw (RegWrite=0) never matches for forwarding or hazard.

## Test plan
- Reset: hold rst_n low 2 cycles while id_valid=1 with R-type 0x411 -> every output is 0 and stall=0. After release, the R-type reaches WB 3 edges later with wb_wreg=id_rd.
- Latency/decoding:
  - Issue lw 0x0A3, rt=5; the next cycle has ex_alu_src=1 and ex_alu_op=00.
  - One edge later mem_read=1.
  - One edge after that wb_mem_to_reg=01, wb_reg_write=1 and wb_wreg=5.
- Load-use:
  - Issue lw to $8, then an R-type with rs=8; stall=1 for exactly one cycle.
  - The EX bubble drives ex_* to 0.
  - The R-type then sees fwd_a=01.
- Forward priority:
  - Issue addi $3, addi $3, then R-type rs=3, rt=3.
  - In EX, fwd_a=fwd_b=10.
  - With one unrelated instruction inserted before the R-type, fwd_a=fwd_b=01.
- Zero/jal/sw:
  - An R-type writing $0 followed by a reader of $0 gives fwd_a=00.
  - jal gives wb_wreg=31.
  - sw to any rt gives no forward and no stall.
- Flush plus stall: assert flush in the load-use cycle -> one bubble, stall=1, and the next issued instruction proceeds normally.
